// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on a
// ready-handshaked memory with an optional timeout, and counts retired instructions.
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter bit ENABLE_JAL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             branch,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              illegal_q, timeout_q;
    logic [CNT_W-1:0]  retired_q;
    logic              retire, set_illegal, set_timeout;
    logic              is_jal, is_legal, wait_hit;

    assign is_jal   = ENABLE_JAL && (opcode == OP_JAL);
    assign is_legal = (opcode == OP_R) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ) || is_jal;
    assign wait_hit = (MEM_TIMEOUT > 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        branch      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXEC: begin
                if (opcode == OP_R) begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_WB;
                end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_ADDI) ? S_WB : S_MEM;
                end else if (opcode == OP_BEQ) begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                    pc_write  = zero;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_jal) begin
                    pc_write = 1'b1;
                    state_d  = S_WB;
                end else begin
                    // Opcode changed under us after DECODE: treat as illegal.
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_MEM: begin
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (mem_ready) begin
                    retire  = (opcode == OP_SW);
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                result_src = (opcode == OP_LW) ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Reset overrides everything so nothing is written while rst is held.
        if (rst) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            branch     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (retire)      retired_q <= retired_q + CNT_W'(1);
            if ((MEM_TIMEOUT > 0) && (state_q == S_FETCH || state_q == S_MEM) &&
                !mem_ready && (state_d == state_q))
                wait_q <= wait_q + WAIT_W'(1);
            else
                wait_q <= '0;
        end
    end

    assign illegal = illegal_q & ~rst;
    assign timeout = timeout_q & ~rst;
    assign state_o = rst ? 3'd0 : state_q;
    assign retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: instance A uses default parameters, instance B uses
// CNT_W=4, MEM_TIMEOUT=4, ENABLE_JAL=0; only the selected one is out of reset.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {ir,pc,mr,mw,rw,src_a,src_b[2],alu_op[2],result_src[2],branch}
    localparam logic [12:0] C_NONE       = 13'b0;
    localparam logic [12:0] C_FETCH_RDY  = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_FETCH_WAIT = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_EXEC_I     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_EXEC_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [12:0] C_BEQ_TAKEN  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b1};
    localparam logic [12:0] C_BEQ_NOT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b1};
    localparam logic [12:0] C_EXEC_JAL   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_MEM_RD     = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_MEM_WR     = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_WB_ALU     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [12:0] C_WB_MEM     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,1'b0};
    localparam logic [12:0] C_WB_PC      = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b10,1'b0};

    logic       clk = 1'b0;
    logic       rst_a, rst_b, sel;
    logic [6:0] opcode;
    logic       zero, mem_ready;

    logic a_ir, a_pc, a_mr, a_mw, a_rw, a_sa, a_br, a_ill, a_to;
    logic b_ir, b_pc, b_mr, b_mw, b_rw, b_sa, b_br, b_ill, b_to;
    logic [1:0] a_sb, a_op, a_rs, b_sb, b_op, b_rs;
    logic [2:0] a_st, b_st;
    logic [31:0] a_ret;
    logic [3:0]  b_ret;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut_a (
        .clk(clk), .rst(rst_a), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ir_write(a_ir), .pc_write(a_pc), .mem_read(a_mr), .mem_write(a_mw),
        .reg_write(a_rw), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_op(a_op),
        .result_src(a_rs), .branch(a_br), .illegal(a_ill), .timeout(a_to),
        .state_o(a_st), .retired(a_ret)
    );

    multicycle_control_unit #(.CNT_W(4), .MEM_TIMEOUT(4), .ENABLE_JAL(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ir_write(b_ir), .pc_write(b_pc), .mem_read(b_mr), .mem_write(b_mw),
        .reg_write(b_rw), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_op(b_op),
        .result_src(b_rs), .branch(b_br), .illegal(b_ill), .timeout(b_to),
        .state_o(b_st), .retired(b_ret)
    );

    logic [12:0] obs_ctl;
    logic [2:0]  obs_state;
    logic [1:0]  obs_flags;
    logic [31:0] obs_ret;
    assign obs_ctl   = sel ? {b_ir,b_pc,b_mr,b_mw,b_rw,b_sa,b_sb,b_op,b_rs,b_br}
                           : {a_ir,a_pc,a_mr,a_mw,a_rw,a_sa,a_sb,a_op,a_rs,a_br};
    assign obs_state = sel ? b_st : a_st;
    assign obs_flags = sel ? {b_ill, b_to} : {a_ill, a_to};
    assign obs_ret   = sel ? {28'b0, b_ret} : a_ret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check state and control word, advance to next cycle.
    task automatic cyc(input string tag, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [2:0] es, input logic [12:0] ec);
        opcode = op; zero = z; mem_ready = rdy;
        #1;
        check({tag, "/state"}, 32'(obs_state), 32'(es));
        check({tag, "/ctl"}, 32'(obs_ctl), 32'(ec));
        @(posedge clk); #1;
    endtask

    task automatic chk_status(input string tag, input logic [1:0] flags, input logic [31:0] ret);
        #1;
        check({tag, "/flags"}, 32'(obs_flags), 32'(flags));
        check({tag, "/retired"}, obs_ret, ret);
    endtask

    // Hold the selected DUT in reset with ready high, confirm outputs are forced low.
    task automatic reset_sel(input string tag);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        opcode = OP_ADDI; zero = 1'b1; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check({tag, "/rst_state"}, 32'(obs_state), 32'd0);
        check({tag, "/rst_ctl"}, 32'(obs_ctl), 32'(C_NONE));
        check({tag, "/rst_flags"}, 32'(obs_flags), 32'd0);
        check({tag, "/rst_retired"}, obs_ret, 32'd0);
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    endtask

    task automatic addi(input string tag);
        cyc({tag, "/F"}, OP_ADDI, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc({tag, "/D"}, OP_ADDI, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc({tag, "/E"}, OP_ADDI, 1'b0, 1'b1, 3'd2, C_EXEC_I);
        cyc({tag, "/W"}, OP_ADDI, 1'b0, 1'b1, 3'd4, C_WB_ALU);
    endtask

    initial begin
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;

        // ---------------- instance A: default parameters ----------------
        reset_sel("A");
        addi("addi");
        chk_status("addi", 2'b00, 32'd1);

        // LW with three wait cycles in FETCH and in MEM
        for (int i = 0; i < 3; i++) cyc("lw/Fw", OP_LW, 1'b0, 1'b0, 3'd0, C_FETCH_WAIT);
        cyc("lw/F", OP_LW, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("lw/D", OP_LW, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("lw/E", OP_LW, 1'b0, 1'b0, 3'd2, C_EXEC_I);
        for (int i = 0; i < 3; i++) cyc("lw/Mw", OP_LW, 1'b0, 1'b0, 3'd3, C_MEM_RD);
        cyc("lw/M", OP_LW, 1'b0, 1'b1, 3'd3, C_MEM_RD);
        cyc("lw/W", OP_LW, 1'b0, 1'b0, 3'd4, C_WB_MEM);
        chk_status("lw", 2'b00, 32'd2);

        // SW: no WB, retires out of MEM
        cyc("sw/F", OP_SW, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("sw/D", OP_SW, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("sw/E", OP_SW, 1'b0, 1'b0, 3'd2, C_EXEC_I);
        cyc("sw/Mw", OP_SW, 1'b0, 1'b0, 3'd3, C_MEM_WR);
        cyc("sw/M", OP_SW, 1'b0, 1'b1, 3'd3, C_MEM_WR);
        chk_status("sw", 2'b00, 32'd3);

        // BEQ taken then not taken
        cyc("beq1/F", OP_BEQ, 1'b1, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("beq1/D", OP_BEQ, 1'b1, 1'b1, 3'd1, C_DECODE);
        cyc("beq1/E", OP_BEQ, 1'b1, 1'b1, 3'd2, C_BEQ_TAKEN);
        chk_status("beq1", 2'b00, 32'd4);
        cyc("beq0/F", OP_BEQ, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("beq0/D", OP_BEQ, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("beq0/E", OP_BEQ, 1'b0, 1'b1, 3'd2, C_BEQ_NOT);
        chk_status("beq0", 2'b00, 32'd5);

        // R-type and JAL
        cyc("r/F", OP_R, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("r/D", OP_R, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("r/E", OP_R, 1'b0, 1'b1, 3'd2, C_EXEC_R);
        cyc("r/W", OP_R, 1'b0, 1'b1, 3'd4, C_WB_ALU);
        cyc("jal/F", OP_JAL, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("jal/D", OP_JAL, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("jal/E", OP_JAL, 1'b0, 1'b1, 3'd2, C_EXEC_JAL);
        cyc("jal/W", OP_JAL, 1'b0, 1'b1, 3'd4, C_WB_PC);
        chk_status("jal", 2'b00, 32'd7);

        // Illegal opcode: trap is absorbing, retired frozen
        cyc("bad/F", OP_BAD, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("bad/D", OP_BAD, 1'b0, 1'b1, 3'd1, C_DECODE);
        for (int i = 0; i < 20; i++) cyc("bad/T", OP_ADDI, 1'b1, 1'b1, 3'd5, C_NONE);
        chk_status("bad", 2'b10, 32'd7);
        reset_sel("A2");

        // Reset during MEM of LW aborts with no write
        cyc("rlw/F", OP_LW, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("rlw/D", OP_LW, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("rlw/E", OP_LW, 1'b0, 1'b0, 3'd2, C_EXEC_I);
        cyc("rlw/Mw", OP_LW, 1'b0, 1'b0, 3'd3, C_MEM_RD);
        rst_a = 1'b1; mem_ready = 1'b1; #1;
        check("rlw/rst_ctl", 32'(obs_ctl), 32'(C_NONE));
        @(posedge clk); #1;
        rst_a = 1'b0;
        cyc("rlw/after", OP_LW, 1'b0, 1'b0, 3'd0, C_FETCH_WAIT);
        chk_status("rlw", 2'b00, 32'd0);
        rst_a = 1'b1;

        // ---------------- instance B: CNT_W=4, MEM_TIMEOUT=4, no JAL ----------------
        sel = 1'b1;
        reset_sel("B");
        cyc("bjal/F", OP_JAL, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("bjal/D", OP_JAL, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("bjal/T", OP_JAL, 1'b0, 1'b1, 3'd5, C_NONE);
        chk_status("bjal", 2'b10, 32'd0);

        // FETCH timeout: five waiting cycles, TRAP after the fifth edge
        reset_sel("B2");
        for (int i = 0; i < 5; i++) cyc("fto/Fw", OP_ADDI, 1'b0, 1'b0, 3'd0, C_FETCH_WAIT);
        cyc("fto/T", OP_ADDI, 1'b0, 1'b0, 3'd5, C_NONE);
        chk_status("fto", 2'b01, 32'd0);

        // Ready arrives in the cycle the count reaches the limit: no timeout
        reset_sel("B3");
        for (int i = 0; i < 4; i++) cyc("rdy/Fw", OP_ADDI, 1'b0, 1'b0, 3'd0, C_FETCH_WAIT);
        cyc("rdy/F", OP_ADDI, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("rdy/D", OP_ADDI, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("rdy/E", OP_ADDI, 1'b0, 1'b1, 3'd2, C_EXEC_I);
        cyc("rdy/W", OP_ADDI, 1'b0, 1'b1, 3'd4, C_WB_ALU);
        chk_status("rdy", 2'b00, 32'd1);

        // Retired counter wraps modulo 16
        for (int i = 0; i < 15; i++) addi("wrap");
        chk_status("wrap16", 2'b00, 32'd0);
        addi("wrap");
        chk_status("wrap17", 2'b00, 32'd1);

        // MEM timeout on a store that never completes
        cyc("mto/F", OP_SW, 1'b0, 1'b1, 3'd0, C_FETCH_RDY);
        cyc("mto/D", OP_SW, 1'b0, 1'b1, 3'd1, C_DECODE);
        cyc("mto/E", OP_SW, 1'b0, 1'b0, 3'd2, C_EXEC_I);
        for (int i = 0; i < 5; i++) cyc("mto/Mw", OP_SW, 1'b0, 1'b0, 3'd3, C_MEM_WR);
        cyc("mto/T", OP_SW, 1'b0, 1'b1, 3'd5, C_NONE);
        chk_status("mto", 2'b01, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
